// File: rtl/count_rr_sched_pkg.sv
// Shared definitions for the round-robin counter scheduler: default widths and FSM encoding.
package count_rr_sched_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/count_rr_sched_core.sv
// Plain enabled up-counter with synchronous clear; clear wins over enable.
module count_core
  import count_rr_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/count_rr_sched.sv
// Round-robin owner of a shared up-counter: grants one requester a timed run of len cycles,
// pulses done on terminal count, and releases early on abort or a dropped request.
module count_rr_sched
  import count_rr_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] len,
  input  logic                   abort,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic                   cnt_en,
  output logic [CNT_W-1:0]       cnt,
  output logic [N_REQ-1:0]       done
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             r_state;
  logic [N_REQ-1:0]   r_grant;
  logic [CNT_W-1:0]   r_len;
  logic [PTR_W-1:0]   r_ptr;

  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [N_REQ-1:0]   w_onehot;
  logic [CNT_W-1:0]   w_len_sel;
  logic               w_take;
  logic               w_owner_req;
  logic               w_terminal;

  // Rotating-priority search starting at r_ptr.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    int idx;
    w_found  = 1'b0;
    w_win    = '0;
    w_onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = idx[PTR_W-1:0];
      end
    end
    w_onehot[w_win] = 1'b1;
  end

  assign w_len_sel   = len[int'(w_win)*CNT_W +: CNT_W];
  assign w_take      = (r_state == ST_IDLE) && w_found && !abort;
  assign w_owner_req = |(req & r_grant);
  assign w_terminal  = (cnt == r_len - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_len   <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_grant <= w_onehot;
            r_len   <= w_len_sel;
            r_ptr   <= (int'(w_win) == N_REQ - 1) ? '0 : w_win + 1'b1;
            r_state <= (w_len_sel == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          // Abort or a dropped owner request beats terminal count on the same edge.
          if (abort || !w_owner_req) begin
            r_grant <= '0;
            r_state <= ST_IDLE;
          end else if (w_terminal) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  count_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_take),
    .en    (cnt_en),
    .cnt   (cnt)
  );

  assign grant  = r_grant;
  assign busy   = (r_state != ST_IDLE);
  assign cnt_en = (r_state == ST_RUN);
  assign done   = (r_state == ST_DONE) ? r_grant : '0;

endmodule

// File: tb/tb_count_rr_sched.sv
// Directed bench for count_rr_sched: hand-computed expectations checked at each falling edge.
module tb_count_rr_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] len;
  logic        abort;
  logic [3:0]  grant;
  logic        busy;
  logic        cnt_en;
  logic [7:0]  cnt;
  logic [3:0]  done;

  int n_vec = 0;
  int n_err = 0;

  count_rr_sched dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .len    (len),
    .abort  (abort),
    .grant  (grant),
    .busy   (busy),
    .cnt_en (cnt_en),
    .cnt    (cnt),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic b,
                           input logic e, input logic [7:0] c, input logic [3:0] d);
    check({tag, ".grant"},  {28'd0, grant}, {28'd0, g});
    check({tag, ".busy"},   {31'd0, busy},  {31'd0, b});
    check({tag, ".cnt_en"}, {31'd0, cnt_en}, {31'd0, e});
    check({tag, ".cnt"},    {24'd0, cnt},   {24'd0, c});
    check({tag, ".done"},   {28'd0, done},  {28'd0, d});
  endtask

  initial begin
    logic [3:0] exp_g;
    rst_n = 1'b0;
    req   = '0;
    len   = '0;
    abort = 1'b0;
    @(negedge clk);
    check_all("reset", 4'b0000, 1'b0, 1'b0, 8'd0, 4'b0000);
    rst_n = 1'b1;

    // 1: single requester, length 5
    req = 4'b0001;
    len[0 +: 8] = 8'd5;
    step();
    check_all("t1.grant", 4'b0001, 1'b1, 1'b1, 8'd0, 4'b0000);
    for (int k = 1; k < 5; k++) begin
      step();
      check_all("t1.run", 4'b0001, 1'b1, 1'b1, 8'(k), 4'b0000);
    end
    step();
    check_all("t1.done", 4'b0001, 1'b1, 1'b0, 8'd5, 4'b0001);
    req = 4'b0000;
    step();
    check_all("t1.idle", 4'b0000, 1'b0, 1'b0, 8'd5, 4'b0000);

    // 2: all requesting, rotation from a fresh pointer
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req = 4'b1111;
    len = 32'h0202_0202;
    for (int r = 0; r < 5; r++) begin
      exp_g = 4'b0001 << (r % 4);
      step();
      check_all("t2.grant", exp_g, 1'b1, 1'b1, 8'd0, 4'b0000);
      step();
      check("t2.cnt1", {24'd0, cnt}, 32'd1);
      step();
      check_all("t2.done", exp_g, 1'b1, 1'b0, 8'd2, exp_g);
      if (r == 4) req = 4'b0000;
      step();
      check_all("t2.idle", 4'b0000, 1'b0, 1'b0, 8'd2, 4'b0000);
    end

    // 3: zero-length run goes straight to DONE
    len[0 +: 8] = 8'd0;
    req = 4'b0001;
    step();
    check_all("t3.grant", 4'b0001, 1'b1, 1'b0, 8'd0, 4'b0001);
    req = 4'b0000;
    step();
    check_all("t3.idle", 4'b0000, 1'b0, 1'b0, 8'd0, 4'b0000);

    // 4: maximum length, no wrap
    len[16 +: 8] = 8'd255;
    req = 4'b0100;
    step();
    check_all("t4.grant", 4'b0100, 1'b1, 1'b1, 8'd0, 4'b0000);
    for (int k = 0; k < 254; k++) step();
    check_all("t4.last", 4'b0100, 1'b1, 1'b1, 8'd254, 4'b0000);
    step();
    check_all("t4.done", 4'b0100, 1'b1, 1'b0, 8'd255, 4'b0100);
    req = 4'b0000;
    step();
    check_all("t4.idle", 4'b0000, 1'b0, 1'b0, 8'd255, 4'b0000);

    // 5a: abort at cnt==4
    len[8 +: 8] = 8'd10;
    req = 4'b0010;
    step();
    check("t5a.grant", {28'd0, grant}, 32'h2);
    for (int k = 0; k < 4; k++) step();
    check("t5a.cnt4", {24'd0, cnt}, 32'd4);
    abort = 1'b1;
    step();
    check_all("t5a.abort", 4'b0000, 1'b0, 1'b0, 8'd5, 4'b0000);
    // abort held in IDLE blocks arbitration
    step();
    check_all("t5a.inhibit", 4'b0000, 1'b0, 1'b0, 8'd5, 4'b0000);
    abort = 1'b0;

    // 5b: owner drops req at cnt==7
    step();
    check_all("t5b.grant", 4'b0010, 1'b1, 1'b1, 8'd0, 4'b0000);
    for (int k = 0; k < 7; k++) step();
    check("t5b.cnt7", {24'd0, cnt}, 32'd7);
    req = 4'b0000;
    step();
    check_all("t5b.drop", 4'b0000, 1'b0, 1'b0, 8'd8, 4'b0000);
    step();
    check_all("t5b.hold", 4'b0000, 1'b0, 1'b0, 8'd8, 4'b0000);

    // 6: async reset mid-run, then pointer search restarts at 0
    len[8 +: 8] = 8'd8;
    req = 4'b0010;
    step();
    check("t6.grant", {28'd0, grant}, 32'h2);
    len[8 +: 8] = 8'd1;
    req = 4'b0011;
    for (int k = 0; k < 3; k++) step();
    check_all("t6.cnt3", 4'b0010, 1'b1, 1'b1, 8'd3, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    check_all("t6.async", 4'b0000, 1'b0, 1'b0, 8'd0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0110;
    len[8 +: 8] = 8'd3;
    step();
    check_all("t6.rearb", 4'b0010, 1'b1, 1'b1, 8'd0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
